btn_cond_multi: RTL and testbench

Multi-channel button conditioner: synchronises, debounces, and edge-detects `NUM_CH` asynchronous push-button inputs. It also classifies presses as short or long, with optional auto-repeat. It sits between board pins and front-panel control logic (watch/stopwatch mode, set, and increment buttons). Every output is a registered level or a one-`clk` pulse in the `clk` domain. All sampling uses a single-cycle tick enable, never a derived clock.

---
 rtl/btn_cond_multi.sv | 186 ++++++++++++++++++
 tb/tb_btn_cond_multi.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cond_multi.sv
// Multi-channel button conditioner: synchroniser, tick-sampled debounce, press/long/repeat classifier.
// Optional feature macro: BTN_REPEAT_EN compiles the auto-repeat counter; without it o_repeat is tied low.
module btn_cond_multi #(
    parameter int NUM_CH       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DIV_TICK     = 100000,
    parameter int DEB_SAMPLES  = 4,
    parameter int HOLD_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_btn,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic [NUM_CH-1:0] o_long,
    output logic [NUM_CH-1:0] o_repeat
);
    localparam int TC_W   = $clog2(DIV_TICK);
    localparam int DC_W   = $clog2(DEB_SAMPLES);
    localparam int HC_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HC_W   = (HC_MAX > 1) ? $clog2(HC_MAX) : 1;

    localparam logic [TC_W-1:0] TC_LAST   = TC_W'(DIV_TICK - 1);
    localparam logic [DC_W-1:0] DC_LAST   = DC_W'(DEB_SAMPLES - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_TICKS - 1);
`ifdef BTN_REPEAT_EN
    localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } state_t;

    // Shared sample-tick divider; all channels sample on the same tick.
    logic [TC_W-1:0] tick_cnt_reg;
    logic            tick;

    assign tick = (tick_cnt_reg == TC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TC_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            logic [DC_W-1:0]        dc_reg;
            logic                   level_reg;
            logic                   press_reg;
            logic                   release_reg;
            logic                   deb_expire;
            logic                   press_ev;
            logic                   release_ev;
            state_t                 state_reg;
            state_t                 state_next;
            logic [HC_W-1:0]        hc_reg;
            logic [HC_W-1:0]        hc_next;
            logic                   long_reg;
            logic                   long_next;
`ifdef BTN_REPEAT_EN
            logic                   repeat_reg;
            logic                   repeat_next;
`endif

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_btn[gi]};
                end
            end

            assign s = sync_reg[SYNC_STAGES-1];

            // The debounced level flips on the tick that completes the disagreeing run.
            assign deb_expire = tick && (s != level_reg) && (dc_reg == DC_LAST);
            assign press_ev   = deb_expire && s;
            assign release_ev = deb_expire && !s;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dc_reg      <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    press_reg   <= press_ev;
                    release_reg <= release_ev;
                    if (tick) begin
                        if (s == level_reg) begin
                            dc_reg <= '0;
                        end else if (dc_reg == DC_LAST) begin
                            level_reg <= s;
                            dc_reg    <= '0;
                        end else begin
                            dc_reg <= dc_reg + DC_W'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg  <= ST_IDLE;
                    hc_reg     <= '0;
                    long_reg   <= 1'b0;
`ifdef BTN_REPEAT_EN
                    repeat_reg <= 1'b0;
`endif
                end else begin
                    state_reg  <= state_next;
                    hc_reg     <= hc_next;
                    long_reg   <= long_next;
`ifdef BTN_REPEAT_EN
                    repeat_reg <= repeat_next;
`endif
                end
            end

            // Release is checked first so it overrides a coincident long/repeat expiry.
            always_comb begin
                state_next  = state_reg;
                hc_next     = hc_reg;
                long_next   = 1'b0;
`ifdef BTN_REPEAT_EN
                repeat_next = 1'b0;
`endif
                if (release_ev) begin
                    state_next = ST_IDLE;
                    hc_next    = '0;
                end else if (press_ev) begin
                    state_next = ST_PRESSED;
                    hc_next    = '0;
                end else if (tick) begin
                    case (state_reg)
                        ST_PRESSED: begin
                            if (hc_reg == HOLD_LAST) begin
                                long_next  = 1'b1;
                                state_next = ST_HELD;
                                hc_next    = '0;
                            end else begin
                                hc_next = hc_reg + HC_W'(1);
                            end
                        end
                        ST_HELD: begin
`ifdef BTN_REPEAT_EN
                            if (hc_reg == REP_LAST) begin
                                repeat_next = 1'b1;
                                hc_next     = '0;
                            end else begin
                                hc_next = hc_reg + HC_W'(1);
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end

            assign o_level[gi]   = level_reg;
            assign o_press[gi]   = press_reg;
            assign o_release[gi] = release_reg;
            assign o_long[gi]    = long_reg;
`ifdef BTN_REPEAT_EN
            assign o_repeat[gi]  = repeat_reg;
`endif
        end
    endgenerate

`ifndef BTN_REPEAT_EN
    assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_btn_cond_multi.sv
// Bench for btn_cond_multi: directed scenarios plus random button activity,
// every cycle compared against a tick/run-length reference model.
module tb_btn_cond_multi;
    localparam int NUM_CH       = 2;
    localparam int SYNC_STAGES  = 2;
    localparam int DIV_TICK     = 4;
    localparam int DEB_SAMPLES  = 3;
    localparam int HOLD_TICKS   = 5;
    localparam int REPEAT_TICKS = 2;
`ifdef BTN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] i_btn;
    logic [NUM_CH-1:0] o_level;
    logic [NUM_CH-1:0] o_press;
    logic [NUM_CH-1:0] o_release;
    logic [NUM_CH-1:0] o_long;
    logic [NUM_CH-1:0] o_repeat;

    btn_cond_multi #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DIV_TICK    (DIV_TICK),
        .DEB_SAMPLES (DEB_SAMPLES),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (i_btn),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_release(o_release),
        .o_long   (o_long),
        .o_repeat (o_repeat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: input delay line, edge count since reset, run lengths, ticks held.
    logic [NUM_CH-1:0] s_line[$];
    int                edge_cnt;
    logic [NUM_CH-1:0] m_lvl;
    int                m_run[NUM_CH];
    bit                m_act[NUM_CH];
    int                m_ht[NUM_CH];
    logic [NUM_CH-1:0] e_press, e_release, e_long, e_repeat;

    int press_cnt[NUM_CH], release_cnt[NUM_CH], long_cnt[NUM_CH], repeat_cnt[NUM_CH];
    int press_cyc[NUM_CH], release_cyc[NUM_CH], long_cyc[NUM_CH];
    bit both_seen;

    task automatic chk(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, edge_cnt, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_edge();
        logic [NUM_CH-1:0] s_old;
        bit is_tick;
        bit prs;
        bit rel;
        e_press   = '0;
        e_release = '0;
        e_long    = '0;
        e_repeat  = '0;
        if (!rst_n) begin
            s_line = {};
            for (int i = 0; i < SYNC_STAGES; i++) s_line.push_back('0);
            edge_cnt = 0;
            m_lvl    = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_run[k] = 0;
                m_act[k] = 1'b0;
                m_ht[k]  = 0;
            end
            return;
        end
        s_old = s_line[0];
        void'(s_line.pop_front());
        s_line.push_back(i_btn);
        edge_cnt++;
        is_tick = (edge_cnt % DIV_TICK) == 0;
        for (int k = 0; k < NUM_CH; k++) begin
            prs = 1'b0;
            rel = 1'b0;
            if (is_tick) begin
                if (s_old[k] == m_lvl[k]) begin
                    m_run[k] = 0;
                end else begin
                    m_run[k]++;
                    if (m_run[k] == DEB_SAMPLES) begin
                        m_lvl[k] = s_old[k];
                        m_run[k] = 0;
                        if (s_old[k]) prs = 1'b1;
                        else          rel = 1'b1;
                    end
                end
            end
            if (rel) begin
                m_act[k] = 1'b0;
            end else if (prs) begin
                m_act[k] = 1'b1;
                m_ht[k]  = 0;
            end else if (m_act[k] && is_tick) begin
                m_ht[k]++;
                if (m_ht[k] == HOLD_TICKS) e_long[k] = 1'b1;
                if (REP_EN && m_ht[k] > HOLD_TICKS && ((m_ht[k] - HOLD_TICKS) % REPEAT_TICKS) == 0)
                    e_repeat[k] = 1'b1;
            end
            e_press[k]   = prs;
            e_release[k] = rel;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("level",   o_level,   m_lvl);
        chk("press",   o_press,   e_press);
        chk("release", o_release, e_release);
        chk("long",    o_long,    e_long);
        chk("repeat",  o_repeat,  e_repeat);
        if (o_press == {NUM_CH{1'b1}}) both_seen = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (o_press[k] === 1'b1)   begin press_cnt[k]++;   press_cyc[k]   = edge_cnt; end
            if (o_release[k] === 1'b1) begin release_cnt[k]++; release_cyc[k] = edge_cnt; end
            if (o_long[k] === 1'b1)    begin long_cnt[k]++;    long_cyc[k]    = edge_cnt; end
            if (o_repeat[k] === 1'b1)  repeat_cnt[k]++;
        end
    endtask

    // kind: 0 press, 1 release, 2 long; a missed pulse within the budget counts as a failure.
    task automatic wait_pulse(input int kind, input int ch, input int budget, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            step();
            case (kind)
                0:       seen = o_press[ch];
                1:       seen = o_release[ch];
                default: seen = o_long[ch];
            endcase
        end
        chk_int(tag, int'(seen), 1);
    endtask

    int saved_long;
    int dur;

    initial begin
        both_seen = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            press_cnt[k] = 0; release_cnt[k] = 0; long_cnt[k] = 0; repeat_cnt[k] = 0;
            press_cyc[k] = 0; release_cyc[k] = 0; long_cyc[k] = 0;
        end
        rst_n = 1'b0;
        i_btn = 2'b11;

        // Reset held with buttons pressed: everything stays low.
        for (int n = 0; n < 10; n++) begin
            step();
            chk("rst_hold", o_level | o_press | o_release | o_long | o_repeat, '0);
        end

        // Clean press on ch0 straight out of reset: ticks at edges 4, 8, 12 -> press at 12.
        rst_n = 1'b1;
        i_btn = 2'b01;
        for (int n = 0; n < 50; n++) step();
        chk_int("clean_press_cnt", press_cnt[0], 1);
        chk_int("clean_press_cyc", press_cyc[0], 12);
        chk_int("clean_long_cyc",  long_cyc[0], 32);
        chk_int("clean_repeat_cnt", repeat_cnt[0], REP_EN ? 2 : 0);
        chk_int("clean_ch1_quiet", press_cnt[1] + release_cnt[1] + long_cnt[1] + repeat_cnt[1], 0);
        i_btn[0] = 1'b0;
        for (int n = 0; n < 20; n++) step();
        chk_int("clean_release_cyc", release_cyc[0], 64);

        // Bounce on ch1: high stretches covering only two samples must be ignored.
        for (int r = 0; r < 2; r++) begin
            i_btn[1] = 1'b1;
            for (int n = 0; n < 8; n++) step();
            i_btn[1] = 1'b0;
            for (int n = 0; n < 8; n++) step();
        end
        chk_int("bounce_no_press", press_cnt[1], 0);
        i_btn[1] = 1'b1;
        for (int n = 0; n < 30; n++) step();
        chk_int("bounce_one_press", press_cnt[1], 1);
        i_btn[1] = 1'b0;
        for (int n = 0; n < 20; n++) step();

        // Short press on ch0: release lands 4 ticks after the press, before the hold expires.
        saved_long = long_cnt[0];
        i_btn[0] = 1'b1;
        wait_pulse(0, 0, 40, "short_press_seen");
        for (int n = 0; n < 4; n++) step();
        i_btn[0] = 1'b0;
        wait_pulse(1, 0, 40, "short_release_seen");
        chk_int("short_release_delay", release_cyc[0] - press_cyc[0], 16);
        for (int n = 0; n < 12; n++) step();
        chk_int("short_no_long", long_cnt[0], saved_long);

        // Release landing on the hold-expiry tick: release wins, no long.
        i_btn[0] = 1'b1;
        wait_pulse(0, 0, 40, "expiry_press_seen");
        for (int n = 0; n < 8; n++) step();
        i_btn[0] = 1'b0;
        wait_pulse(1, 0, 40, "expiry_release_seen");
        chk_int("expiry_release_delay", release_cyc[0] - press_cyc[0], 20);
        for (int n = 0; n < 12; n++) step();
        chk_int("expiry_no_long", long_cnt[0], saved_long);

        // Both channels together, then reset while held.
        both_seen = 1'b0;
        i_btn = 2'b11;
        wait_pulse(2, 0, 80, "both_long_seen");
        chk_int("both_press_same_cycle", int'(both_seen), 1);
        chk("both_long_pair", o_long, 2'b11);
        for (int n = 0; n < 4; n++) step();
        saved_long = release_cnt[0] + release_cnt[1];
        rst_n = 1'b0;
        step();
        chk("mid_reset_outputs", o_level | o_press | o_release | o_long | o_repeat, '0);
        i_btn = 2'b00;
        for (int n = 0; n < 3; n++) step();
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) step();
        chk_int("mid_reset_no_release", release_cnt[0] + release_cnt[1], saved_long);

        // Random activity with occasional resets, checked cycle by cycle by the model.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
            i_btn[$urandom_range(0, NUM_CH - 1)] = 1'(~i_btn[$urandom_range(0, NUM_CH - 1)]);
            if ($urandom_range(0, 3) == 0) i_btn = NUM_CH'($urandom_range(0, 3));
            dur = $urandom_range(1, 45);
            for (int n = 0; n < dur; n++) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
